// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: selects rs1/rs2 operands with MEM/WB bypass, stalls decode on
// unresolved RAW hazards and holds one instruction in the ID/EX pipeline register.
module id_ex_operand_stage #(
    parameter int CTRL_W = 16,
    parameter bit FWD_WB = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [31:0]       rf_rs1_data,
    input  logic [31:0]       rf_rs2_data,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_fwd_ok,
    input  logic [31:0]       mem_data,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_val,
    output logic [31:0]       ex_rs2_val,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              vld_p1;
    logic [31:0]       pc_p1;
    logic [31:0]       rs1_val_p1;
    logic [31:0]       rs2_val_p1;
    logic [31:0]       imm_p1;
    logic [4:0]        rd_p1;
    logic              reg_write_p1;
    logic              mem_read_p1;
    logic [CTRL_W-1:0] ctrl_p1;

    logic [31:0]       rs1_val_p0;
    logic [31:0]       rs2_val_p0;
    logic              stall_p0;

    // The youngest in-flight producer wins: MEM over WB over the regfile; x0 is hardwired.
    function automatic logic [31:0] sel_operand(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic [4:0]  m_rd,
        input logic        m_we,
        input logic        m_ok,
        input logic [31:0] m_val,
        input logic [4:0]  w_rd,
        input logic        w_we,
        input logic [31:0] w_val
    );
        if (src == 5'd0)
            return 32'h0;
        else if (m_we && m_rd == src && m_ok)
            return m_val;
        else if (FWD_WB && w_we && w_rd == src)
            return w_val;
        else
            return rf_val;
    endfunction

    // A result still in EX, or a load in MEM without final data, cannot be bypassed yet.
    function automatic logic src_hazard(
        input logic       uses,
        input logic [4:0] src,
        input logic       e_vld,
        input logic       e_we,
        input logic [4:0] e_rd,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       m_ok
    );
        if (!uses || src == 5'd0)
            return 1'b0;
        else if (e_vld && e_we && e_rd == src)
            return 1'b1;
        else
            return m_we && m_rd == src && !m_ok;
    endfunction

    assign rf_rs1 = id_rs1;
    assign rf_rs2 = id_rs2;

    // Stage p0: operand select and hazard detection on the decode side
    always_comb begin
        rs1_val_p0 = sel_operand(id_rs1, rf_rs1_data, mem_rd, mem_reg_write, mem_fwd_ok,
                                 mem_data, wb_rd, wb_reg_write, wb_data);
        rs2_val_p0 = sel_operand(id_rs2, rf_rs2_data, mem_rd, mem_reg_write, mem_fwd_ok,
                                 mem_data, wb_rd, wb_reg_write, wb_data);
        stall_p0   = src_hazard(id_uses_rs1, id_rs1, vld_p1, reg_write_p1, rd_p1,
                                mem_reg_write, mem_rd, mem_fwd_ok)
                   | src_hazard(id_uses_rs2, id_rs2, vld_p1, reg_write_p1, rd_p1,
                                mem_reg_write, mem_rd, mem_fwd_ok);
    end

    assign id_ready = !rst && !flush && !(id_valid && stall_p0) && (!vld_p1 || ex_ready);

    // Stage p1: ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            rs1_val_p1   <= '0;
            rs2_val_p1   <= '0;
            imm_p1       <= '0;
            rd_p1        <= '0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            ctrl_p1      <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (id_valid && id_ready) begin
            vld_p1       <= 1'b1;
            pc_p1        <= id_pc;
            rs1_val_p1   <= rs1_val_p0;
            rs2_val_p1   <= rs2_val_p0;
            imm_p1       <= id_imm;
            rd_p1        <= id_rd;
            reg_write_p1 <= id_reg_write;
            mem_read_p1  <= id_mem_read;
            ctrl_p1      <= id_ctrl;
        end else if (ex_ready || !vld_p1) begin
            vld_p1 <= 1'b0;
        end
    end

    assign ex_valid     = vld_p1;
    assign ex_pc        = pc_p1;
    assign ex_rs1_val   = rs1_val_p1;
    assign ex_rs2_val   = rs2_val_p1;
    assign ex_imm       = imm_p1;
    assign ex_rd        = rd_p1;
    assign ex_reg_write = reg_write_p1;
    assign ex_mem_read  = mem_read_p1;
    assign ex_ctrl      = ctrl_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed, table-driven bench for id_ex_operand_stage: one vector per clock,
// plus hand-written reset sequences at start and mid-stream.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic [15:0] id_ctrl;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, mem_fwd_ok, wb_reg_write;
    logic [31:0] mem_data, wb_data;
    logic        flush, ex_ready, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [15:0] ex_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_operand_stage #(.CTRL_W(16), .FWD_WB(1'b1)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_fwd_ok(mem_fwd_ok), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        idv;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [31:0] rf1, rf2;
        logic [4:0]  rd;
        logic        rw, mr;
        logic [4:0]  mrd;
        logic        mrw, mok;
        logic [31:0] mdata;
        logic [4:0]  wrd;
        logic        wrw;
        logic [31:0] wdata;
        logic        fl, exr;
        logic        e_rdy, e_vld;
        logic [31:0] e_pc, e_r1, e_r2;
        logic [4:0]  e_rd;
        logic        e_mr;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                                input logic [31:0] rf1, input logic [4:0] rs2, input logic u2,
                                input logic [31:0] rf2, input logic [4:0] rd, input logic rw,
                                input logic mr);
        vec_t v = '0;
        v.idv = 1'b1; v.exr = 1'b1;
        v.pc = pc; v.rs1 = rs1; v.u1 = u1; v.rf1 = rf1;
        v.rs2 = rs2; v.u2 = u2; v.rf2 = rf2; v.rd = rd; v.rw = rw; v.mr = mr;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic rdy, input logic vld,
                                input logic [31:0] pc, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] rd);
        vec_t v = vi;
        v.e_rdy = rdy; v.e_vld = vld; v.e_pc = pc; v.e_r1 = r1; v.e_r2 = r2; v.e_rd = rd;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_valid = v.idv; id_pc = v.pc; id_imm = ~v.pc; id_ctrl = v.pc[15:0];
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_rd = v.rd; id_reg_write = v.rw; id_mem_read = v.mr;
        rf_rs1_data = v.rf1; rf_rs2_data = v.rf2;
        mem_rd = v.mrd; mem_reg_write = v.mrw; mem_fwd_ok = v.mok; mem_data = v.mdata;
        wb_rd = v.wrd; wb_reg_write = v.wrw; wb_data = v.wdata;
        flush = v.fl; ex_ready = v.exr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        // basic regfile read, WB bypass, MEM-over-WB priority, x0, mixed bypass with a load
        vt[0]  = ex(mk(32'h100, 5, 1, 32'h1234, 0, 0, 32'h999, 6, 1, 0), 1, 1, 32'h100, 32'h1234, 0, 6);
        v = mk(32'h104, 7, 1, 32'h0, 8, 1, 32'h88, 9, 0, 0);
        v.wrd = 7; v.wrw = 1; v.wdata = 32'hCAFE;
        vt[1]  = ex(v, 1, 1, 32'h104, 32'hCAFE, 32'h88, 9);
        v = mk(32'h108, 3, 1, 32'h33, 0, 1, 32'h55, 10, 0, 0);
        v.mrd = 3; v.mrw = 1; v.mok = 1; v.mdata = 32'h11; v.wrd = 3; v.wrw = 1; v.wdata = 32'h22;
        vt[2]  = ex(v, 1, 1, 32'h108, 32'h11, 32'h0, 10);
        v = mk(32'h10C, 0, 1, 32'h77, 0, 1, 32'h77, 10, 0, 0);
        v.mrd = 0; v.mrw = 1; v.mok = 1; v.mdata = 32'hEE; v.wrd = 0; v.wrw = 1; v.wdata = 32'hFF;
        vt[3]  = ex(v, 1, 1, 32'h10C, 32'h0, 32'h0, 10);
        v = mk(32'h110, 12, 1, 32'h1, 13, 1, 32'h2, 4, 1, 1);
        v.mrd = 13; v.mrw = 1; v.mok = 1; v.mdata = 32'h333; v.wrd = 12; v.wrw = 1; v.wdata = 32'h222;
        vt[4]  = ex(v, 1, 1, 32'h110, 32'h222, 32'h333, 4);
        vt[4].e_mr = 1'b1;
        // load-use: EX stall, MEM stall without final data, then WB bypass
        vt[5]  = ex(mk(32'h114, 4, 1, 32'h0, 0, 0, 32'h0, 11, 1, 0), 0, 0, 0, 0, 0, 0);
        v = mk(32'h114, 4, 1, 32'h0, 0, 0, 32'h0, 11, 1, 0);
        v.mrd = 4; v.mrw = 1; v.mok = 0; v.mdata = 32'hDEAD;
        vt[6]  = ex(v, 0, 0, 0, 0, 0, 0);
        v = mk(32'h114, 4, 1, 32'h0, 0, 0, 32'h0, 11, 1, 0);
        v.wrd = 4; v.wrw = 1; v.wdata = 32'hBEEF;
        vt[7]  = ex(v, 1, 1, 32'h114, 32'hBEEF, 32'h0, 11);
        // downstream stall for three cycles, then release
        for (int i = 8; i <= 10; i++) begin
            v = mk(32'h118, 1, 1, 32'h101, 0, 0, 32'h0, 2, 1, 0);
            v.exr = 1'b0;
            vt[i] = ex(v, 0, 1, 32'h114, 32'hBEEF, 32'h0, 11);
        end
        vt[11] = ex(mk(32'h118, 1, 1, 32'h101, 0, 0, 32'h0, 2, 1, 0), 1, 1, 32'h118, 32'h101, 0, 2);
        // flush under downstream stall, refill, flush under hazard
        v = mk(32'h11C, 1, 1, 32'h5, 0, 0, 32'h0, 3, 1, 0);
        v.exr = 1'b0; v.fl = 1'b1;
        vt[12] = ex(v, 0, 0, 0, 0, 0, 0);
        vt[13] = ex(mk(32'h120, 15, 1, 32'h15, 0, 0, 32'h0, 14, 1, 0), 1, 1, 32'h120, 32'h15, 0, 14);
        v = mk(32'h124, 14, 1, 32'h0, 0, 0, 32'h0, 3, 1, 0);
        v.fl = 1'b1;
        vt[14] = ex(v, 0, 0, 0, 0, 0, 0);
        // hazard gated by id_valid, then a MEM-only stall
        v = mk(32'h128, 14, 1, 32'h0, 0, 0, 32'h0, 3, 1, 0);
        v.idv = 1'b0; v.mrd = 14; v.mrw = 1; v.mok = 0;
        vt[15] = ex(v, 1, 0, 0, 0, 0, 0);
        v.idv = 1'b1; v.pc = 32'h12C;
        vt[16] = ex(v, 0, 0, 0, 0, 0, 0);
        // EX writer blocks even when MEM could forward the same register
        vt[17] = ex(mk(32'h130, 20, 1, 32'h20, 0, 0, 32'h0, 21, 1, 0), 1, 1, 32'h130, 32'h20, 0, 21);
        v = mk(32'h134, 21, 1, 32'h0, 0, 0, 32'h0, 0, 1, 0);
        v.mrd = 21; v.mrw = 1; v.mok = 1; v.mdata = 32'h555;
        vt[18] = ex(v, 0, 0, 0, 0, 0, 0);
        vt[19] = ex(v, 1, 1, 32'h134, 32'h555, 0, 0);
        // EX writing x0 never stalls an x0 reader
        vt[20] = ex(mk(32'h138, 0, 1, 32'h9, 0, 1, 32'h9, 1, 0, 0), 1, 1, 32'h138, 0, 0, 1);

        // reset with an instruction offered
        rst = 1'b1;
        apply(vt[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst id_ready", {31'b0, id_ready}, 0);
        chk("rst ex_valid", {31'b0, ex_valid}, 0);
        chk("rst ex_pc", ex_pc, 0);
        chk("rst ex_rs1_val", ex_rs1_val, 0);
        chk("rst ex_ctrl", {16'b0, ex_ctrl}, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            #1;
            chk($sformatf("v%0d id_ready", i), {31'b0, id_ready}, {31'b0, vt[i].e_rdy});
            chk($sformatf("v%0d rf_rs1", i), {27'b0, rf_rs1}, {27'b0, vt[i].rs1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, vt[i].e_vld});
            if (vt[i].e_vld) begin
                chk($sformatf("v%0d ex_pc", i), ex_pc, vt[i].e_pc);
                chk($sformatf("v%0d ex_rs1_val", i), ex_rs1_val, vt[i].e_r1);
                chk($sformatf("v%0d ex_rs2_val", i), ex_rs2_val, vt[i].e_r2);
                chk($sformatf("v%0d ex_rd", i), {27'b0, ex_rd}, {27'b0, vt[i].e_rd});
                chk($sformatf("v%0d ex_imm", i), ex_imm, ~vt[i].e_pc);
                chk($sformatf("v%0d ex_ctrl", i), {16'b0, ex_ctrl}, {16'b0, vt[i].e_pc[15:0]});
                chk($sformatf("v%0d ex_mem_read", i), {31'b0, ex_mem_read}, {31'b0, vt[i].e_mr});
            end
        end

        // reset mid-stream drops the held instruction and clears all outputs
        v = mk(32'h200, 2, 1, 32'h2, 0, 0, 32'h0, 5, 1, 1);
        v.exr = 1'b0;
        apply(v);
        rst = 1'b1;
        #1;
        chk("mid rst id_ready", {31'b0, id_ready}, 0);
        @(posedge clk);
        #1;
        chk("mid rst ex_valid", {31'b0, ex_valid}, 0);
        chk("mid rst ex_pc", ex_pc, 0);
        chk("mid rst ex_imm", ex_imm, 0);
        chk("mid rst ex_rd", {27'b0, ex_rd}, 0);
        chk("mid rst ex_reg_write", {31'b0, ex_reg_write}, 0);
        chk("mid rst ex_mem_read", {31'b0, ex_mem_read}, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
